operand_seq: RTL

OPERAND_SEQ -- requirements
Module: operand_seq

---
 rtl/calc_pkg.sv | 27 ++
 rtl/sum_to_bcd.sv | 36 +++
 rtl/operand_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the single-digit add/subtract key sequencer:
// key codes, FSM state encoding and datapath widths.
package calc_pkg;

    localparam int DIGIT_W   = 4;
    localparam int OPERAND_W = 6;

    localparam logic [3:0] KEY_PLUS   = 4'hA;
    localparam logic [3:0] KEY_MINUS  = 4'hB;
    localparam logic [3:0] KEY_EQUALS = 4'hC;
    localparam logic [3:0] KEY_CLEAR  = 4'hF;
    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_A  = 3'd1,
        GOT_OP = 3'd2,
        GOT_B  = 3'd3,
        CALC   = 3'd4,
        SHOW   = 3'd5
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= KEY_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/sum_to_bcd.sv
// Combinational conversion of the adder's 6-bit two's-complement sum into
// a sign flag plus a two-digit BCD magnitude (tens is 0 or 1).
module sum_to_bcd
    import calc_pkg::*;
(
    input  logic [OPERAND_W-1:0] sum,
    output logic                 sign,
    output logic [3:0]           tens,
    output logic [3:0]           ones
);

    logic [OPERAND_W-1:0] mag_s;

    // Sign/magnitude split and decimal digit extraction.
    always_comb begin
        sign  = sum[OPERAND_W-1];
        mag_s = sum;
        tens  = 4'd0;
        ones  = 4'd0;
        if (sign) begin
            mag_s = ~sum + 6'd1;
        end else begin
            mag_s = sum;
        end
        // Magnitude never exceeds 18, so a single subtract-ten suffices;
        // the low nibble of (mag - 10) only depends on the low nibble of mag.
        if (mag_s >= 6'd10) begin
            tens = 4'd1;
            ones = mag_s[3:0] - 4'd10;
        end else begin
            tens = 4'd0;
            ones = mag_s[3:0];
        end
    end

endmodule

// File: rtl/operand_seq.sv
// Key-entry sequencer: collects A, operator and B from a keypad, presents
// the operands to an external adder and holds its result as sign + BCD.
module operand_seq
    import calc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    input  logic [OPERAND_W-1:0] sum_data,
    output logic [OPERAND_W-1:0] a_data,
    output logic [OPERAND_W-1:0] b_data,
    output logic                 sub_sel,
    output logic                 result_valid,
    output logic                 result_sign,
    output logic [3:0]           result_tens,
    output logic [3:0]           result_ones
);

    state_t               state_r, state_next_s;
    logic [DIGIT_W-1:0]   a_r, a_next_s;
    logic [DIGIT_W-1:0]   b_r, b_next_s;
    logic                 op_r, op_next_s;
    logic [OPERAND_W-1:0] b_data_r, b_data_next_s;
    logic                 valid_r, valid_next_s;
    logic                 sign_r, sign_next_s;
    logic [3:0]           tens_r, tens_next_s;
    logic [3:0]           ones_r, ones_next_s;

    logic                 key_digit_s;
    logic                 key_op_s;
    logic                 key_eq_s;
    logic                 key_clr_s;
    logic                 conv_sign_s;
    logic [3:0]           conv_tens_s;
    logic [3:0]           conv_ones_s;

    assign key_digit_s = key_valid && is_digit(key_code);
    assign key_op_s    = key_valid && ((key_code == KEY_PLUS) || (key_code == KEY_MINUS));
    assign key_eq_s    = key_valid && (key_code == KEY_EQUALS);
    assign key_clr_s   = key_valid && (key_code == KEY_CLEAR);

    sum_to_bcd u_sum_to_bcd (
        .sum  (sum_data),
        .sign (conv_sign_s),
        .tens (conv_tens_s),
        .ones (conv_ones_s)
    );

    // Next-state and next-data decode for the entry sequence.
    always_comb begin
        state_next_s = state_r;
        a_next_s     = a_r;
        b_next_s     = b_r;
        op_next_s    = op_r;
        valid_next_s = valid_r;
        sign_next_s  = sign_r;
        tens_next_s  = tens_r;
        ones_next_s  = ones_r;

        if (key_clr_s) begin
            state_next_s = IDLE;
            a_next_s     = 4'd0;
            b_next_s     = 4'd0;
            op_next_s    = 1'b0;
            valid_next_s = 1'b0;
            sign_next_s  = 1'b0;
            tens_next_s  = 4'd0;
            ones_next_s  = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (key_digit_s) begin
                        a_next_s     = key_code;
                        state_next_s = GOT_A;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                GOT_A: begin
                    if (key_digit_s) begin
                        a_next_s = key_code;
                    end else if (key_op_s) begin
                        op_next_s    = (key_code == KEY_MINUS);
                        state_next_s = GOT_OP;
                    end else begin
                        state_next_s = GOT_A;
                    end
                end
                GOT_OP: begin
                    if (key_op_s) begin
                        op_next_s = (key_code == KEY_MINUS);
                    end else if (key_digit_s) begin
                        b_next_s     = key_code;
                        state_next_s = GOT_B;
                    end else begin
                        state_next_s = GOT_OP;
                    end
                end
                GOT_B: begin
                    if (key_digit_s) begin
                        b_next_s = key_code;
                    end else if (key_eq_s) begin
                        state_next_s = CALC;
                    end else begin
                        state_next_s = GOT_B;
                    end
                end
                CALC: begin
                    valid_next_s = 1'b1;
                    sign_next_s  = conv_sign_s;
                    tens_next_s  = conv_tens_s;
                    ones_next_s  = conv_ones_s;
                    state_next_s = SHOW;
                end
                SHOW: begin
                    if (key_digit_s) begin
                        valid_next_s = 1'b0;
                        a_next_s     = key_code;
                        state_next_s = GOT_A;
                    end else begin
                        state_next_s = SHOW;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end

        // B is pre-inverted in its register so the adder sees a stable operand.
        if (op_next_s) begin
            b_data_next_s = ~{2'b00, b_next_s};
        end else begin
            b_data_next_s = {2'b00, b_next_s};
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            a_r      <= 4'd0;
            b_r      <= 4'd0;
            op_r     <= 1'b0;
            b_data_r <= 6'd0;
            valid_r  <= 1'b0;
            sign_r   <= 1'b0;
            tens_r   <= 4'd0;
            ones_r   <= 4'd0;
        end else begin
            state_r  <= state_next_s;
            a_r      <= a_next_s;
            b_r      <= b_next_s;
            op_r     <= op_next_s;
            b_data_r <= b_data_next_s;
            valid_r  <= valid_next_s;
            sign_r   <= sign_next_s;
            tens_r   <= tens_next_s;
            ones_r   <= ones_next_s;
        end
    end

    assign a_data       = {2'b00, a_r};
    assign b_data       = b_data_r;
    assign sub_sel      = op_r;
    assign result_valid = valid_r;
    assign result_sign  = sign_r;
    assign result_tens  = tens_r;
    assign result_ones  = ones_r;

endmodule
